// File: rtl/sa_feeder_pkg.sv
// Shared types and sizing helpers for the systolic-array operand feeder.
package sa_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Index width for row/column addresses, never below one bit.
    function automatic int iw_f(input int m, input int k, input int n);
        int w;
        w = $clog2(max3(m, k, n));
        return (w < 1) ? 1 : w;
    endfunction

    // Counter width covering both the beat index and the drain count.
    function automatic int cw_f(input int m, input int k, input int n, input int drain);
        int w;
        int wd;
        w  = $clog2(k + m + n - 1);
        wd = $clog2(drain + 1);
        if (wd > w) w = wd;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sa_operand_feeder_if.sv
// Write port and skewed operand stream of the feeder, bundled for one connection.
interface sa_operand_feeder_if #(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
);
    import sa_feeder_pkg::*;

    localparam int IW = iw_f(M, K, N);

    logic                         wr_en;
    logic                         wr_sel;
    logic [IW-1:0]                wr_row;
    logic [IW-1:0]                wr_col;
    logic signed [DATA_WIDTH-1:0] wr_data;
    logic                         wr_drop;
    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         acc_clr;
    logic [M*DATA_WIDTH-1:0]      a_out;
    logic [M-1:0]                 a_vld;
    logic [N*DATA_WIDTH-1:0]      b_out;
    logic [N-1:0]                 b_vld;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  wr_drop, busy, done, acc_clr, a_out, a_vld, b_out, b_vld
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output wr_drop, busy, done, acc_clr, a_out, a_vld, b_out, b_vld
    );

endinterface

// File: rtl/sa_operand_bank.sv
// Operand register file: one range-checked write port, combinational indexed reads
// that see a same-cycle write (write-first).
module sa_operand_bank
    import sa_feeder_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int IW   = 2,
    parameter int NRD  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_row,
    input  logic [IW-1:0]            wr_col,
    input  logic signed [DW-1:0]     wr_data,
    output logic                     wr_ok,
    input  logic [NRD-1:0][IW-1:0]   rd_row,
    input  logic [NRD-1:0][IW-1:0]   rd_col,
    output logic [NRD-1:0][DW-1:0]   rd_data
);

    logic signed [DW-1:0] mem_q [ROWS][COLS];
    logic signed [DW-1:0] mem_d [ROWS][COLS];
    logic                 we;

    assign wr_ok = (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    assign we    = wr_en && wr_ok;

    always_comb begin
        mem_d = mem_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (we && (wr_row == IW'(r)) && (wr_col == IW'(c))) mem_d[r][c] = wr_data;
            end
        end
    end

    // Reads come from mem_d so a write and a start in the same cycle stream the new value.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if ((rd_row[p] == IW'(r)) && (rd_col[p] == IW'(c))) rd_data[p] = mem_d[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/sa_operand_feeder.sv
// Buffers A (MxK) and B (KxN) and streams them as diagonally skewed wavefronts
// into an output-stationary systolic array; done marks C = A*B in the accumulators.
module sa_operand_feeder
    import sa_feeder_pkg::*;
#(
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DRAIN_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    sa_operand_feeder_if.slave   bus
);

    localparam int IW = iw_f(M, K, N);
    localparam int CW = cw_f(M, K, N, DRAIN_CYC);
    localparam int T  = K + M + N - 2;
    localparam logic [CW-1:0] LAST_BEAT  = CW'(T - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYC - 1);

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            acc_clr_q, acc_clr_d;
    logic                            drop_q, drop_d;
    logic [M-1:0][DATA_WIDTH-1:0]    a_out_q, a_out_d;
    logic [M-1:0]                    a_vld_q, a_vld_d;
    logic [N-1:0][DATA_WIDTH-1:0]    b_out_q, b_out_d;
    logic [N-1:0]                    b_vld_q, b_vld_d;

    logic                            beat_en;
    logic [CW-1:0]                   beat;
    logic                            idle, a_ok, b_ok, a_we, b_we;
    logic [M-1:0][IW-1:0]            a_rd_row, a_rd_col;
    logic [N-1:0][IW-1:0]            b_rd_row, b_rd_col;
    logic [M-1:0][DATA_WIDTH-1:0]    a_rd;
    logic [N-1:0][DATA_WIDTH-1:0]    b_rd;

    assign idle = (state_q == ST_IDLE);
    assign a_we = bus.wr_en && idle && !bus.wr_sel;
    assign b_we = bus.wr_en && idle &&  bus.wr_sel;

    sa_operand_bank #(.ROWS(M), .COLS(K), .DW(DATA_WIDTH), .IW(IW), .NRD(M)) u_bank_a (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (a_we),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .wr_ok   (a_ok),
        .rd_row  (a_rd_row),
        .rd_col  (a_rd_col),
        .rd_data (a_rd)
    );

    sa_operand_bank #(.ROWS(K), .COLS(N), .DW(DATA_WIDTH), .IW(IW), .NRD(N)) u_bank_b (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (b_we),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .wr_ok   (b_ok),
        .rd_row  (b_rd_row),
        .rd_col  (b_rd_col),
        .rd_data (b_rd)
    );

    // beat/beat_en name the beat that will be on the outputs after this edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_clr_d = 1'b0;
        beat_en   = 1'b0;
        beat      = '0;
        drop_d    = bus.wr_en && !(idle && (bus.wr_sel ? b_ok : a_ok));
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_STREAM;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    acc_clr_d = 1'b1;
                    beat_en   = 1'b1;
                end
            end
            ST_STREAM: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    beat_en = 1'b1;
                    beat    = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST_DRAIN) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Skew: row i of A and column j of B lag the wavefront by i and j beats.
    always_comb begin
        int d;
        d        = 0;
        a_rd_row = '0;
        a_rd_col = '0;
        a_vld_d  = '0;
        b_rd_row = '0;
        b_rd_col = '0;
        b_vld_d  = '0;
        for (int i = 0; i < M; i++) begin
            d = int'(beat) - i;
            a_rd_row[i] = IW'(i);
            if (beat_en && (d >= 0) && (d < K)) begin
                a_vld_d[i]  = 1'b1;
                a_rd_col[i] = IW'(d);
            end
        end
        for (int j = 0; j < N; j++) begin
            d = int'(beat) - j;
            b_rd_col[j] = IW'(j);
            if (beat_en && (d >= 0) && (d < K)) begin
                b_vld_d[j]  = 1'b1;
                b_rd_row[j] = IW'(d);
            end
        end
    end

    always_comb begin
        a_out_d = '0;
        b_out_d = '0;
        for (int i = 0; i < M; i++) if (a_vld_d[i]) a_out_d[i] = a_rd[i];
        for (int j = 0; j < N; j++) if (b_vld_d[j]) b_out_d[j] = b_rd[j];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            drop_q    <= 1'b0;
            a_out_q   <= '0;
            a_vld_q   <= '0;
            b_out_q   <= '0;
            b_vld_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_clr_q <= acc_clr_d;
            drop_q    <= drop_d;
            a_out_q   <= a_out_d;
            a_vld_q   <= a_vld_d;
            b_out_q   <= b_out_d;
            b_vld_q   <= b_vld_d;
        end
    end

    assign bus.wr_drop = drop_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.acc_clr = acc_clr_q;
    assign bus.a_out   = a_out_q;
    assign bus.a_vld   = a_vld_q;
    assign bus.b_out   = b_out_q;
    assign bus.b_vld   = b_vld_q;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Bench for sa_operand_feeder: a 4x4x4 instance and a 2x3x5 instance, checked against
// a matrix model and an emulated output-stationary array fed by the observed stream.
module tb_sa_operand_feeder;

    localparam int DRAIN = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       dsel;
    logic       wr_en, wr_sel, start;
    logic [2:0] wr_row, wr_col;
    logic [7:0] wr_data;

    logic [31:0] o_a_out;
    logic [39:0] o_b_out;
    logic [3:0]  o_a_vld;
    logic [4:0]  o_b_vld;
    logic        o_busy, o_done, o_acc_clr, o_wr_drop;

    int n_cmp = 0;
    int n_err = 0;
    int cm, ck, cn;
    int ma[5][5], mb[5][5];
    int obs_a[5][16], obs_b[5][16], sav_a[5][16], sav_b[5][16];
    int c_obs[5][5];
    logic [4:0] rec_av[16], rec_bv[16];

    int a_init[4][4] = '{'{1, 0, -2, 3}, '{4, -1, 5, 6}, '{7, 2, -3, 8}, '{-9, 4, 0, -7}};
    int b_init[4][4] = '{'{2, -3, 1, 4}, '{5, 6, -2, -1}, '{-3, 7, 8, 0}, '{0, 2, -5, 9}};

    sa_operand_feeder_if #(.M(4), .K(4), .N(4), .DATA_WIDTH(8)) bus0 ();
    sa_operand_feeder_if #(.M(2), .K(3), .N(5), .DATA_WIDTH(8)) bus1 ();

    sa_operand_feeder #(.M(4), .K(4), .N(4), .DATA_WIDTH(8), .DRAIN_CYC(DRAIN)) u_dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    sa_operand_feeder #(.M(2), .K(3), .N(5), .DATA_WIDTH(8), .DRAIN_CYC(DRAIN)) u_dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    assign bus0.wr_en   = wr_en & ~dsel;
    assign bus0.wr_sel  = wr_sel;
    assign bus0.wr_row  = wr_row[1:0];
    assign bus0.wr_col  = wr_col[1:0];
    assign bus0.wr_data = wr_data;
    assign bus0.start   = start & ~dsel;
    assign bus1.wr_en   = wr_en & dsel;
    assign bus1.wr_sel  = wr_sel;
    assign bus1.wr_row  = wr_row;
    assign bus1.wr_col  = wr_col;
    assign bus1.wr_data = wr_data;
    assign bus1.start   = start & dsel;

    assign o_a_out   = dsel ? {16'b0, bus1.a_out} : bus0.a_out;
    assign o_b_out   = dsel ? bus1.b_out : {8'b0, bus0.b_out};
    assign o_a_vld   = dsel ? {2'b0, bus1.a_vld} : bus0.a_vld;
    assign o_b_vld   = dsel ? bus1.b_vld : {1'b0, bus0.b_vld};
    assign o_busy    = dsel ? bus1.busy : bus0.busy;
    assign o_done    = dsel ? bus1.done : bus0.done;
    assign o_acc_clr = dsel ? bus1.acc_clr : bus0.acc_clr;
    assign o_wr_drop = dsel ? bus1.wr_drop : bus0.wr_drop;

    task automatic chk(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic void clear_model();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
    endfunction

    // Expected beat t straight from the matrices: row i carries A[i][t-i], column j carries B[t-j][j].
    function automatic void exp_beat(input int t, output longint av, output longint bv,
                                     output longint ao, output longint bo);
        av = 0; bv = 0; ao = 0; bo = 0;
        for (int i = 0; i < cm; i++)
            if (t - i >= 0 && t - i < ck) begin
                av |= longint'(1) << i;
                ao |= longint'(ma[i][t - i] & 255) << (8 * i);
            end
        for (int j = 0; j < cn; j++)
            if (t - j >= 0 && t - j < ck) begin
                bv |= longint'(1) << j;
                bo |= longint'(mb[t - j][j] & 255) << (8 * j);
            end
    endfunction

    task automatic wr(input bit sel, input int row, input int col, input int val, input string tag);
        bit ok;
        ok = (row < (sel ? ck : cm)) && (col < (sel ? cn : ck));
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_row = 3'(row); wr_col = 3'(col); wr_data = 8'(val);
        @(negedge clk);
        wr_en = 1'b0;
        chk(tag, o_wr_drop, !ok);
        if (ok) begin
            if (sel) mb[row][col] = val;
            else     ma[row][col] = val;
        end
    endtask

    // mode 0 plain, 1 write+start while busy, 2 reset at beat 5, 3 write together with start
    task automatic run_stream(input string tag, input int mode);
        int t_tot, w, nd, nv;
        longint av, bv, ao, bo;
        t_tot = ck + cm + cn - 2;
        nv = 0;
        @(negedge clk);
        start = 1'b1;
        if (mode == 3) begin
            nv = (mb[0][0] == 77) ? -77 : 77;
            wr_en = 1'b1; wr_sel = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'(nv);
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        if (mode == 3) begin
            mb[0][0] = nv;
            chk({tag, " write+start drop"}, o_wr_drop, 0);
        end
        for (int t = 0; t < t_tot; t++) begin
            exp_beat(t, av, bv, ao, bo);
            chk($sformatf("%s beat%0d a_vld", tag, t), o_a_vld, av);
            chk($sformatf("%s beat%0d b_vld", tag, t), o_b_vld, bv);
            chk($sformatf("%s beat%0d a_out", tag, t), o_a_out, ao);
            chk($sformatf("%s beat%0d b_out", tag, t), o_b_out, bo);
            chk($sformatf("%s beat%0d busy", tag, t), o_busy, 1);
            chk($sformatf("%s beat%0d acc_clr", tag, t), o_acc_clr, (t == 0));
            rec_av[t] = {1'b0, o_a_vld};
            rec_bv[t] = o_b_vld;
            for (int i = 0; i < cm; i++) obs_a[i][t] = o_a_vld[i] ? int'($signed(o_a_out[i*8 +: 8])) : 0;
            for (int j = 0; j < cn; j++) obs_b[j][t] = o_b_vld[j] ? int'($signed(o_b_out[j*8 +: 8])) : 0;
            if (mode == 1 && t == 3) chk({tag, " drop in stream"}, o_wr_drop, 1);
            if (mode == 1 && t == 4) chk({tag, " drop one cycle"}, o_wr_drop, 0);
            if (mode == 2 && t == 5) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk({tag, " abort vld"}, {o_a_vld, o_b_vld}, 0);
                chk({tag, " abort a_out"}, o_a_out, 0);
                chk({tag, " abort b_out"}, o_b_out, 0);
                chk({tag, " abort busy"}, o_busy, 0);
                chk({tag, " abort acc_clr"}, o_acc_clr, 0);
                clear_model();
                nd = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (o_done) nd++;
                end
                chk({tag, " done after abort"}, nd, 0);
                return;
            end
            if (mode == 1 && t == 2) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'd99;
                start = 1'b1;
            end
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
        end
        w = 0;
        while (!o_done && w < 40) begin
            chk({tag, " drain busy"}, o_busy, 1);
            chk({tag, " drain vld"}, {o_a_vld, o_b_vld}, 0);
            @(negedge clk);
            w++;
        end
        chk({tag, " start-to-done cycles"}, t_tot + w, t_tot + DRAIN);
        chk({tag, " busy at done"}, o_busy, 0);
        if (mode == 1) begin
            nd = 0;
            repeat (15) begin
                @(negedge clk);
                if (o_done) nd++;
            end
            chk({tag, " extra done pulses"}, nd, 0);
            chk({tag, " idle after run"}, o_busy, 0);
        end
    endtask

    // Emulate PE(i,j): A row i arrives j beats late, B column j arrives i beats late.
    task automatic check_product(input string tag);
        int t_tot, acc, gold, sa, sb;
        t_tot = ck + cm + cn - 2;
        for (int i = 0; i < cm; i++)
            for (int j = 0; j < cn; j++) begin
                acc = 0;
                for (int c = 0; c < t_tot + cm + cn; c++) begin
                    sa = c - j;
                    sb = c - i;
                    if (sa >= 0 && sa < t_tot && sb >= 0 && sb < t_tot) acc += obs_a[i][sa] * obs_b[j][sb];
                end
                gold = 0;
                for (int k = 0; k < ck; k++) gold += ma[i][k] * mb[k][j];
                c_obs[i][j] = acc;
                chk($sformatf("%s C[%0d][%0d]", tag, i, j), acc, gold);
            end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int diff;
        rst = 1'b1; dsel = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        cm = 4; ck = 4; cn = 4;
        clear_model();
        repeat (3) @(negedge clk);
        chk("reset busy", o_busy, 0);
        chk("reset done", o_done, 0);
        chk("reset acc_clr", o_acc_clr, 0);
        chk("reset vld", {o_a_vld, o_b_vld}, 0);
        chk("reset a_out", o_a_out, 0);
        chk("reset b_out", o_b_out, 0);
        chk("reset drop", o_wr_drop, 0);
        chk("reset dut1 busy", bus1.busy, 0);
        rst = 1'b0;

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr(1'b0, r, c, a_init[r][c], "t1 write A");
                wr(1'b1, r, c, b_init[r][c], "t1 write B");
            end
        run_stream("t1", 0);
        chk("t1 beat0 a_out0", obs_a[0][0], 1);
        chk("t1 beat0 b_out0", obs_b[0][0], 2);
        chk("t1 beat0 a_vld", rec_av[0], 1);
        chk("t1 beat0 b_vld", rec_bv[0], 1);
        chk("t1 beat3 a_out3", obs_a[3][3], -9);
        chk("t1 beat3 b_out3", obs_b[3][3], 4);
        chk("t1 beat3 vld", {rec_av[3], rec_bv[3]}, {5'd15, 5'd15});
        chk("t1 beat6 a_vld", rec_av[6], 8);
        chk("t1 beat6 a_out3", obs_a[3][6], -7);
        chk("t1 beat6 b_vld", rec_bv[6], 8);
        chk("t1 beat6 b_out3", obs_b[3][6], 9);
        check_product("t2");
        chk("t2 C00", c_obs[0][0], 8);
        chk("t2 C13", c_obs[1][3], 71);
        chk("t2 C22", c_obs[2][2], -61);
        chk("t2 C33", c_obs[3][3], -103);

        sav_a = obs_a;
        sav_b = obs_b;
        run_stream("t5", 0);
        diff = 0;
        for (int i = 0; i < 4; i++)
            for (int t = 0; t < 10; t++)
                if (obs_a[i][t] != sav_a[i][t] || obs_b[i][t] != sav_b[i][t]) diff++;
        chk("t5 repeat stream diffs", diff, 0);

        run_stream("t3", 1);
        check_product("t3");

        run_stream("t4", 2);
        run_stream("t4 zero", 0);
        check_product("t4 zero");

        dsel = 1'b1;
        cm = 2; ck = 3; cn = 5;
        clear_model();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) wr(1'b0, r, c, int'($urandom_range(0, 255)) - 128, "t6 write A");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) wr(1'b1, r, c, int'($urandom_range(0, 255)) - 128, "t6 write B");
        wr(1'b0, 4, 0, 55, "t3 A row4 drop");
        wr(1'b0, 2, 1, 55, "t3 A row2 drop");
        wr(1'b0, 0, 3, 55, "t3 A col3 drop");
        wr(1'b1, 3, 0, 55, "t3 B row3 drop");
        wr(1'b1, 0, 5, 55, "t3 B col5 drop");
        run_stream("t6", 3);
        check_product("t6");
        run_stream("t6 rerun", 0);
        check_product("t6 rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
